sobremuestreo_tx: RTL and testbench

Oversampling transmitter for the low-pass majority filter path. It accepts a SAMPLES-bit symbol word over a valid/ready handshake and emits it serially, MSB first, repeating each bit OSF times at the sample rate. It also maintains the SAMPLES*OSF-bit sample window and a one-cycle frame strobe P, so its outputs connect directly to the filter's DataIn/P inputs. It sits at the transmit end of the oversampled link and serves as the reference stimulus source for the filter.

---
 rtl/sobremuestreo_tx.sv | 100 ++++++++++
 tb/tb_sobremuestreo_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobremuestreo_tx.sv
// sobremuestreo_tx: oversampling serial transmitter.
// Accepts a SAMPLES-bit word over Valid/Ready and sends it out MSB first.
// Each bit is repeated OSF times, one sample per Tick. The block also keeps a
// sliding W-sample window and raises a one-cycle frame strobe P, so it can
// drive the majority filter's DataIn/P inputs directly.
// Ports:
//   Clk, RstN  clock, asynchronous active-low reset
//   Tick       sample-rate enable (only used while sending)
//   DataIn     symbol word, sampled on acceptance
//   Valid      DataIn valid
//   Ready      can accept a word (combinational, idle state)
//   SerOut     registered serial sample
//   DataOut    registered sample window, newest sample in bit 0
//   P          registered frame-complete strobe, one Clk cycle
//   Busy       registered, frame in progress
module sobremuestreo_tx #(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  localparam int W      = SAMPLES * OSF
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               Tick,
  input  logic [SAMPLES-1:0] DataIn,
  input  logic               Valid,
  output logic               Ready,
  output logic               SerOut,
  output logic [W-1:0]       DataOut,
  output logic               P,
  output logic               Busy
);

  localparam int SCW = (OSF > 1) ? $clog2(OSF) : 1;
  localparam int BCW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [SCW-1:0] SUB_LAST = SCW'(OSF - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(SAMPLES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [SAMPLES-1:0] sh;
  logic [SCW-1:0]     subcnt;
  logic [BCW-1:0]     bitcnt;
  logic               cur;

  assign cur   = sh[SAMPLES-1];
  assign Ready = (state == IDLE);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state   <= IDLE;
      sh      <= '0;
      subcnt  <= '0;
      bitcnt  <= '0;
      SerOut  <= 1'b0;
      DataOut <= '0;
      P       <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      // Strobe lasts exactly one cycle whatever Tick does.
      P <= 1'b0;
      case (state)
        IDLE: begin
          // Tick is deliberately ignored here: the first sample waits for
          // the first Tick strictly after acceptance.
          if (Valid) begin
            sh     <= DataIn;
            subcnt <= '0;
            bitcnt <= '0;
            state  <= SEND;
            Busy   <= 1'b1;
          end
        end
        SEND: begin
          if (Tick) begin
            SerOut  <= cur;
            DataOut <= {DataOut[W-2:0], cur};
            if (subcnt == SUB_LAST) begin
              subcnt <= '0;
              sh     <= sh << 1;
              if (bitcnt == BIT_LAST) begin
                // Last sample of the frame: counters stop, block reopens
                // so a word offered during the P cycle is taken next edge.
                P     <= 1'b1;
                state <= IDLE;
                Busy  <= 1'b0;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end else begin
              subcnt <= subcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobremuestreo_tx.sv
module tb_sobremuestreo_tx;

  localparam int MS = 2;
  localparam int MO = 8;
  localparam int MW = MS * MO;

  logic          Clk = 1'b0;
  logic          RstN = 1'b0;
  logic          Tick = 1'b1;
  logic [MS-1:0] DataIn = '0;
  logic          Valid = 1'b0;
  logic          Ready, SerOut, P, Busy;
  logic [MW-1:0] DataOut;

  // sweep instances
  logic       v1 = 1'b0, r1, s1, p1, b1;
  logic [0:0] d1 = '0;
  logic [3:0] o1;
  logic       v3 = 1'b0, r3, s3, p3, b3;
  logic [2:0] d3 = '0;
  logic [5:0] o3;

  int checks = 0;
  int errors = 0;
  int pcnt   = 0;
  int cyc    = 0;
  bit sparse = 1'b0;

  sobremuestreo_tx #(.SAMPLES(MS), .OSF(MO)) dut (
    .Clk(Clk), .RstN(RstN), .Tick(Tick), .DataIn(DataIn), .Valid(Valid),
    .Ready(Ready), .SerOut(SerOut), .DataOut(DataOut), .P(P), .Busy(Busy));

  sobremuestreo_tx #(.SAMPLES(1), .OSF(4)) u1 (
    .Clk(Clk), .RstN(RstN), .Tick(Tick), .DataIn(d1), .Valid(v1),
    .Ready(r1), .SerOut(s1), .DataOut(o1), .P(p1), .Busy(b1));

  sobremuestreo_tx #(.SAMPLES(3), .OSF(2)) u3 (
    .Clk(Clk), .RstN(RstN), .Tick(Tick), .DataIn(d3), .Valid(v3),
    .Ready(r3), .SerOut(s3), .DataOut(o3), .P(p3), .Busy(b3));

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick source: continuous, or one Tick every third cycle.
  initial forever begin
    @(posedge Clk);
    #1;
    cyc++;
    Tick = sparse ? (cyc % 3 == 0) : 1'b1;
  end

  // Behavioural model: a frame is a queue of samples (each word bit
  // repeated OSF times, MSB first) drained one per Tick.
  bit          m_busy = 1'b0, m_ser = 1'b0, m_p = 1'b0;
  logic [MW-1:0] m_win = '0;
  bit          m_q[$];
  initial forever begin
    @(posedge Clk or negedge RstN);
    if (!RstN) begin
      m_busy = 0; m_ser = 0; m_p = 0; m_win = '0; m_q.delete();
    end else begin
      m_p = 0;
      if (!m_busy) begin
        if (Valid) begin
          for (int i = MS - 1; i >= 0; i--)
            for (int j = 0; j < MO; j++) m_q.push_back(DataIn[i]);
          m_busy = 1;
        end
      end else if (Tick) begin
        m_ser = m_q.pop_front();
        m_win = {m_win[MW-2:0], m_ser};
        if (m_q.size() == 0) begin
          m_p = 1;
          m_busy = 0;
        end
      end
    end
  end

  // Compare process: every cycle, all main-instance outputs vs the model.
  initial forever begin
    @(negedge Clk);
    chk("serout", 32'(SerOut), 32'(m_ser));
    chk("dataout", 32'(DataOut), 32'(m_win));
    chk("p", 32'(P), 32'(m_p));
    chk("busy", 32'(Busy), 32'(m_busy));
    chk("ready", 32'(Ready), 32'(!m_busy));
  end

  initial forever begin
    @(negedge Clk);
    if (P) pcnt++;
  end

  task automatic accept(input int which, input logic [2:0] d);
    @(posedge Clk);
    #1;
    case (which)
      0: begin Valid = 1'b1; DataIn = d[MS-1:0]; end
      1: begin v1 = 1'b1; d1 = d[0:0]; end
      default: begin v3 = 1'b1; d3 = d; end
    endcase
    @(posedge Clk);
    #1;
    Valid = 1'b0; v1 = 1'b0; v3 = 1'b0;
  endtask

  // Counts negedges until the selected P is seen; n=0 is the cycle right
  // after the acceptance edge.
  task automatic wait_pulse(input int which, input int budget, output int n);
    logic pp;
    n = 0;
    forever begin
      @(negedge Clk);
      case (which)
        0: pp = P;
        1: pp = p1;
        default: pp = p3;
      endcase
      if (pp) break;
      n++;
      if (n > budget) begin
        chk("p_timeout", 32'(n), 32'(budget));
        break;
      end
    end
  endtask

  int n, pbase;

  initial begin
    // reset state
    #12;
    chk("rst_ser", 32'(SerOut), 0);
    chk("rst_dout", 32'(DataOut), 0);
    chk("rst_ready", 32'(Ready), 1);
    @(negedge Clk);
    RstN = 1'b1;

    // reset in the middle of a frame of 2'b11
    accept(0, 3'b011);
    repeat (5) @(posedge Clk);
    #2;
    RstN = 1'b0;
    #1;
    chk("midrst_ser", 32'(SerOut), 0);
    chk("midrst_dout", 32'(DataOut), 32'h0000);
    chk("midrst_p", 32'(P), 0);
    chk("midrst_busy", 32'(Busy), 0);
    chk("midrst_ready", 32'(Ready), 1);
    @(negedge Clk);
    RstN = 1'b1;
    accept(0, 3'b001);
    wait_pulse(0, 40, n);
    chk("after_rst_dout", 32'(DataOut), 32'h00FF);
    chk("after_rst_lat", 32'(n), 16);

    // basic frame 2'b10
    accept(0, 3'b010);
    wait_pulse(0, 40, n);
    chk("basic_lat", 32'(n), 16);
    chk("basic_dout", 32'(DataOut), 32'hFF00);
    chk("basic_pop", 32'($countones(DataOut)), 8);
    chk("basic_ready_at_p", 32'(Ready), 1);
    @(negedge Clk);
    chk("basic_p_one_cycle", 32'(P), 0);

    // sparse Tick, every third cycle
    sparse = 1'b1;
    accept(0, 3'b001);
    wait_pulse(0, 200, n);
    chk("sparse_dout", 32'(DataOut), 32'h00FF);
    sparse = 1'b0;

    // back-to-back: 2'b11 then 2'b00 offered in the P cycle
    pbase = pcnt;
    @(posedge Clk);
    #1;
    Valid = 1'b1; DataIn = 2'b11;
    wait_pulse(0, 40, n);
    chk("b2b_first", 32'(DataOut), 32'hFFFF);
    DataIn = 2'b00;
    @(posedge Clk);
    #1;
    Valid = 1'b0;
    @(negedge Clk);
    chk("b2b_accepted", 32'(Busy), 1);
    wait_pulse(0, 40, n);
    chk("b2b_second", 32'(DataOut), 32'h0000);
    repeat (20) @(negedge Clk);
    chk("b2b_pulses", 32'(pcnt - pbase), 2);
    chk("b2b_idle", 32'(Busy), 0);

    // Valid while busy is ignored
    pbase = pcnt;
    accept(0, 3'b010);
    repeat (3) @(posedge Clk);
    #1;
    Valid = 1'b1; DataIn = 2'b01;
    @(posedge Clk);
    #1;
    Valid = 1'b0;
    wait_pulse(0, 40, n);
    chk("busy_ign_dout", 32'(DataOut), 32'hFF00);
    repeat (20) @(negedge Clk);
    chk("busy_ign_pulses", 32'(pcnt - pbase), 1);
    chk("busy_ign_idle", 32'(Busy), 0);

    // parameter sweep
    accept(1, 3'b001);
    wait_pulse(1, 20, n);
    chk("s1o4_lat", 32'(n), 4);
    chk("s1o4_dout", 32'(o1), 32'hF);
    accept(2, 3'b101);
    wait_pulse(2, 20, n);
    chk("s3o2_lat", 32'(n), 6);
    chk("s3o2_dout", 32'(o3), 32'b110011);

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
